// File: rtl/rs232_tx_arbiter.sv
// Round-robin arbiter sharing one RS-232 transmitter between N_REQ byte sources.
// Optional macro RS232_ARB_LOCK_EN keeps the grant on one requester until its req_last byte.
module rs232_tx_arbiter #(
    parameter int N_REQ       = 4,
    parameter int DATA_W      = 8,
    parameter int ACK_TIMEOUT = 15,
    localparam int GW         = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    input  logic [N_REQ-1:0]        req_last,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    tx_start,
    output logic [DATA_W-1:0]       tx_data,
    input  logic                    tx_busy,
    output logic                    grant_valid,
    output logic [GW-1:0]           grant_id,
    output logic                    tx_err
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_LAUNCH    = 2'd1;
    localparam logic [1:0] S_WAIT_ACK  = 2'd2;
    localparam logic [1:0] S_WAIT_DONE = 2'd3;
    localparam int CW = $clog2(ACK_TIMEOUT + 1);

    logic [1:0]        state_q, state_d;
    logic [GW-1:0]     last_q, last_d;
    logic [GW-1:0]     grant_id_q, grant_id_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic              grant_valid_q, grant_valid_d;
    logic              tx_err_q, tx_err_d;
    logic [CW-1:0]     ack_cnt_q, ack_cnt_d;

    logic [N_REQ-1:0]  eligible;
    logic [N_REQ-1:0]  ready_vec;
    logic              win_found;
    logic [GW-1:0]     win_idx;
    logic [DATA_W-1:0] req_bytes [N_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_bytes
            assign req_bytes[gi] = req_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

`ifdef RS232_ARB_LOCK_EN
    logic          lock_q, lock_d;
    logic [GW-1:0] lock_id_q, lock_id_d;

    // While locked, only the requester that owns the open message may compete.
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_elig
            assign eligible[gi] = req_valid[gi] & (~lock_q | (lock_id_q == GW'(gi)));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_q    <= 1'b0;
            lock_id_q <= '0;
        end else begin
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
        end
    end
`else
    logic unused_req_last;
    assign unused_req_last = ^req_last;
    assign eligible        = req_valid;
`endif

    // Rotating scan starting just after the last served requester.
    always_comb begin
        int            idx;
        logic [GW-1:0] idx_g;
        idx       = 0;
        idx_g     = '0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx   = (int'(last_q) + k) % N_REQ;
            idx_g = GW'(idx);
            if (!win_found && eligible[idx_g]) begin
                win_found = 1'b1;
                win_idx   = idx_g;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        last_d        = last_q;
        grant_id_d    = grant_id_q;
        tx_data_d     = tx_data_q;
        grant_valid_d = grant_valid_q;
        tx_err_d      = tx_err_q;
        ack_cnt_d     = ack_cnt_q;
        ready_vec     = '0;
`ifdef RS232_ARB_LOCK_EN
        lock_d        = lock_q;
        lock_id_d     = lock_id_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!tx_busy && win_found) begin
                    ready_vec[win_idx] = 1'b1;
                    tx_data_d          = req_bytes[win_idx];
                    grant_id_d         = win_idx;
                    grant_valid_d      = 1'b1;
                    state_d            = S_LAUNCH;
`ifdef RS232_ARB_LOCK_EN
                    lock_d             = ~req_last[win_idx];
                    lock_id_d          = win_idx;
`endif
                end
            end
            S_LAUNCH: begin
                // Counter holds the number of cycles elapsed since tx_start.
                ack_cnt_d = CW'(1);
                state_d   = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (tx_busy) begin
                    state_d = S_WAIT_DONE;
                end else if (ack_cnt_q >= CW'(ACK_TIMEOUT - 1)) begin
                    tx_err_d      = 1'b1;
                    last_d        = grant_id_q;
                    grant_valid_d = 1'b0;
                    state_d       = S_IDLE;
`ifdef RS232_ARB_LOCK_EN
                    lock_d        = 1'b0;
`endif
                end else begin
                    ack_cnt_d = ack_cnt_q + 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy) begin
`ifdef RS232_ARB_LOCK_EN
                    if (!lock_q) begin
                        last_d = grant_id_q;
                    end
`else
                    last_d = grant_id_q;
`endif
                    grant_valid_d = 1'b0;
                    state_d       = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            last_q        <= GW'(N_REQ - 1);
            grant_id_q    <= '0;
            tx_data_q     <= '0;
            grant_valid_q <= 1'b0;
            tx_err_q      <= 1'b0;
            ack_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            last_q        <= last_d;
            grant_id_q    <= grant_id_d;
            tx_data_q     <= tx_data_d;
            grant_valid_q <= grant_valid_d;
            tx_err_q      <= tx_err_d;
            ack_cnt_q     <= ack_cnt_d;
        end
    end

    assign req_ready   = rst ? '0 : ready_vec;
    assign tx_start    = (state_q == S_LAUNCH);
    assign tx_data     = tx_data_q;
    assign grant_valid = grant_valid_q;
    assign grant_id    = grant_id_q;
    assign tx_err      = tx_err_q;

endmodule

// File: tb/tb_rs232_tx_arbiter.sv
// Bench for rs232_tx_arbiter: table of single requests, fairness, busy, timeout, reset and lock sequences.
module tb_rs232_tx_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int TO = 15;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic           tx_start;
    logic [W-1:0]   tx_data;
    logic           tx_busy;
    logic           grant_valid;
    logic [1:0]     grant_id;
    logic           tx_err;

    rs232_tx_arbiter #(.N_REQ(N), .DATA_W(W), .ACK_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
        .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
        .grant_valid(grant_valid), .grant_id(grant_id), .tx_err(tx_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transmitter model: busy rises two cycles after tx_start and lasts busy_len cycles.
    int   model_en   = 1;
    int   busy_len   = 20;
    logic force_busy = 1'b0;
    logic mpend      = 1'b0;
    logic mbusy      = 1'b0;
    int   blen       = 0;
    assign tx_busy = force_busy | mbusy;

    always @(posedge clk) begin
        if (mpend) begin
            mpend <= 1'b0;
            mbusy <= 1'b1;
            blen  <= busy_len - 1;
        end else if (mbusy) begin
            if (blen == 0) mbusy <= 1'b0;
            else           blen  <= blen - 1;
        end
        if (tx_start && model_en != 0 && !rst) mpend <= 1'b1;
    end

    // Requester sources
    logic [W-1:0] src_data [N][8];
    logic         src_last [N][8];
    int           src_n    [N];
    int           src_pos  [N];

    function automatic void drive_inputs();
        for (int i = 0; i < N; i++) begin
            if (src_pos[i] < src_n[i]) begin
                req_valid[i]       = 1'b1;
                req_data[i*W +: W] = src_data[i][src_pos[i]];
                req_last[i]        = src_last[i][src_pos[i]];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[i*W +: W] = '0;
                req_last[i]        = 1'b0;
            end
        end
    endfunction

    task automatic load(input int r, input logic [W-1:0] d, input logic l);
        src_data[r][src_n[r]] = d;
        src_last[r][src_n[r]] = l;
        src_n[r]++;
        drive_inputs();
    endtask

    // Scoreboard
    typedef struct {
        logic [1:0]   id;
        logic [W-1:0] data;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    task automatic expect_tx(input logic [1:0] id, input logic [W-1:0] d);
        exp_t e;
        e.id   = id;
        e.data = d;
        exp_q.push_back(e);
    endtask

    int           start_log[$];
    int           fall_log[$];
    int           gv_fall_log[$];
    int           err_log[$];
    int           ready_cyc[$];
    logic [N-1:0] ready_mask[$];

    function automatic void clear_logs();
        start_log.delete();
        fall_log.delete();
        gv_fall_log.delete();
        err_log.delete();
        ready_cyc.delete();
        ready_mask.delete();
    endfunction

    logic busy_prev = 1'b0;
    logic gv_prev   = 1'b0;
    logic err_prev  = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (tx_start) begin
                start_log.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_tx_start: got id %0d data %0h, expected no launch", grant_id, tx_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    $display("tx id=%0d data=%0h at cycle %0d", grant_id, tx_data, cyc);
                    chk("tx_data", 32'(tx_data), 32'(mon_e.data));
                    chk("grant_id", 32'(grant_id), 32'(mon_e.id));
                    chk("grant_valid_at_start", 32'(grant_valid), 32'd1);
                end
            end
            if (req_ready != '0) begin
                ready_cyc.push_back(cyc);
                ready_mask.push_back(req_ready);
                chk("ready_onehot", 32'($countones(req_ready)), 32'd1);
                chk("ready_not_busy", 32'(tx_busy), 32'd0);
            end
            if (busy_prev && !tx_busy)   fall_log.push_back(cyc);
            if (gv_prev && !grant_valid) gv_fall_log.push_back(cyc);
            if (!err_prev && tx_err)     err_log.push_back(cyc);
        end
        busy_prev = tx_busy;
        gv_prev   = grant_valid;
        err_prev  = tx_err;
    end

    task automatic tick();
        logic [N-1:0] acc;
        @(negedge clk);
        acc = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (acc[i]) src_pos[i]++;
        drive_inputs();
    endtask

    task automatic wait_idle(input string name, input int budget);
        logic done;
        done = 1'b0;
        for (int t = 0; t < budget && !done; t++) begin
            done = !grant_valid && !tx_busy && !mpend;
            for (int i = 0; i < N; i++) if (src_pos[i] < src_n[i]) done = 1'b0;
            if (!done) tick();
        end
        chk(name, 32'(done), 32'd1);
        tick();
        tick();
    endtask

    task automatic do_reset();
        for (int i = 0; i < N; i++) begin
            src_n[i]   = 0;
            src_pos[i] = 0;
        end
        drive_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        clear_logs();
    endtask

    typedef struct {
        int           id;
        logic [W-1:0] data;
        int           blen;
        logic [N-1:0] exp_ready;
    } vec_t;
    vec_t vecs[4];

    initial begin
        int rel;
        vecs[0] = '{2, 8'h35, 20, 4'b0100};
        vecs[1] = '{0, 8'h5A,  3, 4'b0001};
        vecs[2] = '{3, 8'hFF,  1, 4'b1000};
        vecs[3] = '{1, 8'h00,  5, 4'b0010};

        for (int i = 0; i < N; i++) begin
            src_n[i]   = 0;
            src_pos[i] = 0;
        end
        drive_inputs();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_tx_start", 32'(tx_start), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_grant_valid", 32'(grant_valid), 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        chk("rst_tx_err", 32'(tx_err), 32'd0);
        @(posedge clk);
        #1;

        // Single-request vectors
        for (int v = 0; v < 4; v++) begin
            clear_logs();
            busy_len = vecs[v].blen;
            load(vecs[v].id, vecs[v].data, 1'b1);
            expect_tx(2'(vecs[v].id), vecs[v].data);
            wait_idle("vec_idle", 200);
            chk("vec_ready_count", 32'(ready_cyc.size()), 32'd1);
            chk("vec_start_count", 32'(start_log.size()), 32'd1);
            if (ready_cyc.size() == 1 && start_log.size() == 1 && fall_log.size() == 1 && gv_fall_log.size() == 1) begin
                chk("vec_ready_mask", 32'(ready_mask[0]), 32'(vecs[v].exp_ready));
                chk("vec_start_latency", 32'(start_log[0] - ready_cyc[0]), 32'd1);
                chk("vec_idle_after_fall", 32'(gv_fall_log[0] - fall_log[0]), 32'd1);
            end else begin
                chk("vec_event_counts", 32'(fall_log.size() + gv_fall_log.size()), 32'd2);
            end
        end

        // Fairness: all requesters continuously valid
        do_reset();
        busy_len = 4;
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N; i++) begin
                load(i, 8'hA0 + 8'(i), 1'b1);
            end
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N; i++) expect_tx(2'(i), 8'hA0 + 8'(i));
        wait_idle("fair_idle", 400);
        chk("fair_start_count", 32'(start_log.size()), 32'd8);
        if (start_log.size() == 8 && fall_log.size() >= 7) begin
            for (int k = 1; k < 8; k++)
                chk("fair_back_to_back", 32'(start_log[k] - fall_log[k-1]), 32'd2);
        end

        // Busy at idle
        force_busy = 1'b1;
        do_reset();
        load(0, 8'hC3, 1'b1);
        expect_tx(2'd0, 8'hC3);
        for (int t = 0; t < 10; t++) tick();
        chk("busy_no_ready", 32'(ready_cyc.size()), 32'd0);
        force_busy = 1'b0;
        rel = cyc;
        tick();
        chk("busy_release_ready", 32'(ready_cyc.size()), 32'd1);
        if (ready_cyc.size() == 1) begin
            chk("busy_release_cycle", 32'(ready_cyc[0]), 32'(rel));
            chk("busy_release_mask", 32'(ready_mask[0]), 32'b0001);
        end
        wait_idle("busy_idle", 200);

        // Ack timeout
        do_reset();
        model_en = 0;
        load(1, 8'h77, 1'b1);
        expect_tx(2'd1, 8'h77);
        wait_idle("timeout_idle", 200);
        chk("timeout_err", 32'(tx_err), 32'd1);
        chk("timeout_err_rises", 32'(err_log.size()), 32'd1);
        if (err_log.size() == 1 && start_log.size() == 1)
            chk("timeout_delay", 32'(err_log[0] - start_log[0]), 32'(TO));
        model_en = 1;
        busy_len = 6;
        clear_logs();
        load(2, 8'h42, 1'b1);
        expect_tx(2'd2, 8'h42);
        wait_idle("after_timeout_idle", 200);
        chk("after_timeout_served", 32'(start_log.size()), 32'd1);
        chk("err_sticky", 32'(tx_err), 32'd1);

        // Reset in WAIT_DONE
        do_reset();
        busy_len = 20;
        load(2, 8'h99, 1'b1);
        expect_tx(2'd2, 8'h99);
        begin
            int t;
            for (t = 0; t < 50 && !(grant_valid && tx_busy); t++) tick();
            chk("midframe_reached", 32'(grant_valid && tx_busy), 32'd1);
        end
        tick();
        load(0, 8'h11, 1'b1);
        load(3, 8'h33, 1'b1);
        expect_tx(2'd0, 8'h11);
        expect_tx(2'd3, 8'h33);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_tx_start", 32'(tx_start), 32'd0);
        chk("midrst_grant_valid", 32'(grant_valid), 32'd0);
        chk("midrst_grant_id", 32'(grant_id), 32'd0);
        chk("midrst_tx_data", 32'(tx_data), 32'd0);
        chk("midrst_tx_err", 32'(tx_err), 32'd0);
        chk("midrst_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        wait_idle("midrst_idle", 400);
        chk("midrst_served", 32'(exp_q.size()), 32'd0);

        // Multi-byte message from requester 1 competing with requester 0
        do_reset();
        busy_len = 3;
        load(0, 8'hE0, 1'b1);
        expect_tx(2'd0, 8'hE0);
        wait_idle("lock_pre_idle", 200);
        load(1, 8'hB1, 1'b0);
        load(1, 8'hB2, 1'b0);
        load(1, 8'hB3, 1'b1);
        load(0, 8'hC0, 1'b1);
`ifdef RS232_ARB_LOCK_EN
        expect_tx(2'd1, 8'hB1);
        expect_tx(2'd1, 8'hB2);
        expect_tx(2'd1, 8'hB3);
        expect_tx(2'd0, 8'hC0);
`else
        expect_tx(2'd1, 8'hB1);
        expect_tx(2'd0, 8'hC0);
        expect_tx(2'd1, 8'hB2);
        expect_tx(2'd1, 8'hB3);
`endif
        wait_idle("lock_idle", 400);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rs232_tx_arbiter.md
# rs232_tx_arbiter

Round-robin arbiter and sequencer that shares the single RS-232 transmitter of `RS_232_top` between `N_REQ` on-chip byte sources, such as the RX echo path, a status reporter and a debug port. It accepts one byte at a time from a winning requester over a valid/ready handshake and launches it with a one-cycle start pulse. It then tracks the transmitter's busy flag until the frame completes. It sits between the requesters and the UART TX core in the same `clk` domain.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `DATA_W`, 8: byte width.
- `ACK_TIMEOUT`, 15: max cycles after `tx_start` for `tx_busy` to rise.
- `GW`, `$clog2(N_REQ)`: grant index width (local parameter).

- `clk` in 1: system clock (100 MHz in the top level).
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in N_REQ: requester i has a byte.
- `req_data` in N_REQ*DATA_W: requester i byte at `[i*DATA_W +: DATA_W]`.
- `req_last` in N_REQ: byte is the last of a frame; used only with the lock feature.
- `req_ready` out N_REQ: one-hot accept; a transfer occurs when valid & ready.
- `tx_start` out 1: one-cycle launch pulse to the transmitter.
- `tx_data` out DATA_W: byte to send, stable from `tx_start` until return to IDLE.
- `tx_busy` in 1: transmitter frame in progress.
- `grant_valid` out 1: a byte is in flight.
- `grant_id` out GW: index of the current or last granted requester.
- `tx_err` out 1: sticky flag; the transmitter never acknowledged.

## Operation
- **Reset values:** `req_ready`=0, `tx_start`=0, `tx_data`=0, `grant_valid`=0, `grant_id`=0, `tx_err`=0. Round-robin pointer `last`=N_REQ-1, so requester 0 wins first. Lock cleared. State IDLE.
- **FSM:** IDLE → LAUNCH → WAIT_ACK → WAIT_DONE → IDLE.
- **IDLE**
  - When `tx_busy`=0 and any eligible `req_valid`, select the winner w as the first valid index scanning last+1, last+2, … modulo N_REQ.
  - Drive `req_ready[w]`=1 combinationally in that cycle.
  - On the edge: latch `tx_data`←byte w, `grant_id`←w, then go to LAUNCH.
  - With `tx_busy`=1, no `req_ready`.
- **LAUNCH:** `tx_start`=1 for exactly this cycle; `grant_valid`=1; go to WAIT_ACK.
- **WAIT_ACK**
  - If `tx_busy`=1, go to WAIT_DONE.
  - If `tx_busy` is still 0 after `ACK_TIMEOUT` cycles: set `tx_err`=1, update `last`, and go to IDLE (byte dropped).
- **WAIT_DONE:** when `tx_busy`=0, set `last`←`grant_id` (unless locked), `grant_valid`←0, and go to IDLE.
- **Other rules:**
  - `req_ready` is 0 in every state except IDLE.
  - At most one `req_ready` bit is high in any cycle.
  - A requester that drops `req_valid` before it is granted loses nothing; no state is held for it.
  - `tx_err` is cleared only by `rst`.
- **Reset mid-operation:** the FSM returns to IDLE next cycle, `tx_start` deasserts, and the pointer and lock reset. The transmitter's current frame is not aborted by this block. IDLE then waits for `tx_busy`=0 before granting.

## Timing
- Acceptance in cycle N → `tx_start` in cycle N+1 (latency 1).
- `grant_valid` is high from N+1 until the cycle after `tx_busy` falls.
- Back-to-back transfers: if `tx_busy` falls at cycle M, the next acceptance can occur at M+1 and the next `tx_start` at M+2.
- At 9600 baud, a frame holds the arbiter for about 104,170 cycles.
- Simultaneous requests resolve the same cycle by the rotating scan; no requester waits more than N_REQ-1 grants.

## Configuration
- **`RS232_ARB_LOCK_EN` defined:**
  - Accepting a byte with `req_last[w]`=0 sets lock on w.
  - While locked, only requester w is eligible, and `last` is not advanced.
  - Accepting a byte with `req_last[w]`=1 clears the lock and advances `last`←w.
  - A timeout also clears the lock.
  - Multi-byte messages are therefore never interleaved.
- **Not defined:** `req_last` is ignored, no lock logic is built, and grants rotate per byte.

## Test plan
- **Single request.** After reset, `req_valid`=4'b0100, data[2]=8'h35, bench TX model raises busy 2 cycles after start for 20 cycles.
  - `req_ready`=4'b0100 one cycle, then `tx_start` the next cycle with `tx_data`=8'h35, `grant_id`=2.
  - Return to IDLE one cycle after busy falls.
- **Fairness.** All four valid continuously with bytes 8'hA0..8'hA3.
  - Grant order 0,1,2,3,0.
  - Consecutive `tx_start` pulses 2 cycles past each busy fall.
- **Busy at idle.** `tx_busy`=1 from reset for 10 cycles with `req_valid`=4'b0001.
  - No `req_ready` until the cycle busy is 0.
- **Timeout.** TX model never raises busy.
  - `tx_err`=1 exactly 15 cycles after `tx_start`, FSM back to IDLE.
  - Next request is served normally; `tx_err` stays 1 until `rst`.
- **Reset mid-frame.** Assert `rst` one cycle in WAIT_DONE.
  - All outputs at reset values next cycle, `grant_id`=0.
  - Pending requester 0 is granted first after busy drops.
- **Lock, with `RS232_ARB_LOCK_EN`.** Requester 1 sends 3 bytes (`req_last`=0,0,1) while requester 0 is valid.
  - Grants 1,1,1,0.
  - Without the macro: 1,0,1,…
